// File: rtl/fpadd_rr_sched_if.sv
// Bundle of requester-side and adder-side signals around fpadd_rr_sched.
// The scheduler uses the slave modport; the requesters and adder side use master.
interface fpadd_rr_sched_if #(
    parameter int NREQ = 4
);
    logic                 en;
    logic [NREQ-1:0]      req;
    logic [NREQ*64-1:0]   a_in;
    logic [NREQ*64-1:0]   b_in;
    logic [NREQ-1:0]      gnt;
    logic [63:0]          fa;
    logic [63:0]          fb;
    logic                 fpush;
    logic [63:0]          fr;
    logic                 fpushout;
    logic [63:0]          r_out;
    logic [NREQ-1:0]      rvalid;
    logic                 idle;
    logic                 tag_err;

    modport slave (
        input  en, req, a_in, b_in, fr, fpushout,
        output gnt, fa, fb, fpush, r_out, rvalid, idle, tag_err
    );

    modport master (
        output en, req, a_in, b_in, fr, fpushout,
        input  gnt, fa, fb, fpush, r_out, rvalid, idle, tag_err
    );
endinterface

// File: rtl/fpadd_rr_sched.sv
// Round-robin scheduler sharing one pipelined 64-bit fpadd among NREQ
// requesters. A tag pipe follows each issued operation through the adder
// and steers the result back to the requester that issued it.
module fpadd_rr_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 4,
    parameter int TW   = 3
) (
    input  logic            clk,
    input  logic            rst,
    fpadd_rr_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]            ptr_q, ptr_d;
    logic [63:0]              fa_q, fa_d;
    logic [63:0]              fb_q, fb_d;
    logic                     fpush_q, fpush_d;
    logic [TW-1:0]            itag_q, itag_d;
    logic [LAT-1:0]           pv_q, pv_d;
    logic [LAT-1:0][TW-1:0]   pt_q, pt_d;
    logic [63:0]              r_q, r_d;
    logic [NREQ-1:0]          rv_q, rv_d;
    logic                     err_q, err_d;

    logic [NREQ-1:0]          gnt_c;
    logic                     any_gnt;
    logic [IW-1:0]            gidx;
    logic [IW-1:0]            cand;

    // Pick the first pending requester after ptr_q, wrapping modulo NREQ.
    always_comb begin
        gnt_c   = '0;
        any_gnt = 1'b0;
        gidx    = '0;
        cand    = '0;
        if (rst && bus.en) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand = IW'((32'(ptr_q) + k) % NREQ);
                if (!any_gnt && bus.req[cand]) begin
                    any_gnt = 1'b1;
                    gidx    = cand;
                end
            end
            if (any_gnt) begin
                gnt_c[gidx] = 1'b1;
            end
        end
    end

    // Next-state for issue stage, tag pipe and result return path.
    // itag_q rides alongside fpush_q; the LAT-stage pipe behind them puts
    // stage LAT-1 in the same cycle as the adder's pushout.
    always_comb begin
        ptr_d   = ptr_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fpush_d = any_gnt;
        itag_d  = itag_q;
        if (any_gnt) begin
            ptr_d  = gidx;
            fa_d   = bus.a_in[64*gidx +: 64];
            fb_d   = bus.b_in[64*gidx +: 64];
            itag_d = TW'(gidx);
        end

        pv_d    = '0;
        pt_d    = '0;
        pv_d[0] = fpush_q;
        pt_d[0] = itag_q;
        for (int unsigned k = 1; k < LAT; k++) begin
            pv_d[k] = pv_q[k-1];
            pt_d[k] = pt_q[k-1];
        end

        r_d  = bus.fpushout ? bus.fr : r_q;
        rv_d = '0;
        if (bus.fpushout) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                rv_d[i] = (pt_q[LAT-1] == TW'(i));
            end
        end

        err_d = err_q | (bus.fpushout != pv_q[LAT-1]);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q   <= IW'(NREQ - 1);
            fa_q    <= '0;
            fb_q    <= '0;
            fpush_q <= 1'b0;
            itag_q  <= '0;
            pv_q    <= '0;
            pt_q    <= '0;
            r_q     <= '0;
            rv_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fpush_q <= fpush_d;
            itag_q  <= itag_d;
            pv_q    <= pv_d;
            pt_q    <= pt_d;
            r_q     <= r_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign bus.gnt     = gnt_c;
    assign bus.fa      = fa_q;
    assign bus.fb      = fb_q;
    assign bus.fpush   = fpush_q;
    assign bus.r_out   = r_q;
    assign bus.rvalid  = rv_q;
    assign bus.tag_err = err_q;
    assign bus.idle    = (gnt_c == '0) && !fpush_q && (pv_q == '0) && !bus.fpushout;

endmodule
